dtc_inverse_enum: RTL and testbench

DTC_INVERSE_ENUM -- requirements
Module: dtc_inverse_enum

---
 rtl/dtc_pkg.sv | 49 ++++
 rtl/dtc_node_ram.sv | 26 ++
 rtl/dtc_inverse_enum.sv | 150 +++++++++++++++
 tb/tb_dtc_inverse_enum.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/dtc_pkg.sv
// rtl/dtc_pkg.sv - shared types and constants for the decision-tree inverse enumerator
// Contents: node word layout (packed struct and field offsets), FSM state enum,
// input/class widths, feature-index helper and node-word builder.
package dtc_pkg;

    localparam int INP_W = 7;
    localparam int CLS_W = 2;

    // Field offsets inside the 16-bit node word
    localparam int NODE_LEAF_OFS = 15;
    localparam int NODE_FEAT_OFS = 12;
    localparam int NODE_CLS_OFS  = 10;
    localparam int NODE_LO_OFS   = 5;
    localparam int NODE_HI_OFS   = 0;

    typedef struct packed {
        logic             leaf;
        logic [2:0]       feat;
        logic [CLS_W-1:0] cls;
        logic [4:0]       lo_child;
        logic [4:0]       hi_child;
    } node_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WALK = 2'd1,
        S_EMIT = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    // The input vector is only 7 bits wide, so feature 7 aliases onto bit 6.
    function automatic logic [2:0] feat_idx(input logic [2:0] f);
        return (f == 3'd7) ? 3'd6 : f;
    endfunction

    function automatic logic [15:0] make_node(input logic leaf, input logic [2:0] feat,
                                              input logic [1:0] cls, input logic [4:0] lo,
                                              input logic [4:0] hi);
        logic [15:0] w;
        w = '0;
        w[NODE_LEAF_OFS]                 = leaf;
        w[NODE_FEAT_OFS +: 3]            = feat;
        w[NODE_CLS_OFS +: CLS_W]         = cls;
        w[NODE_LO_OFS +: 5]              = lo;
        w[NODE_HI_OFS +: 5]              = hi;
        return w;
    endfunction

endpackage

// File: rtl/dtc_node_ram.sv
// rtl/dtc_node_ram.sv - node table, one synchronous write port and one asynchronous read port
// Ports: clk; we/waddr/wdata write port; raddr/rdata combinational read port.
// Contents are deliberately not reset.
module dtc_node_ram #(
    parameter int N_NODES = 32,
    parameter int AW      = $clog2(N_NODES)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [15:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [15:0]   rdata
);

    logic [15:0] r_mem [N_NODES];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule

// File: rtl/dtc_inverse_enum.sv
// rtl/dtc_inverse_enum.sv - enumerates, in ascending order, all 7-bit inputs a decision tree maps to a class
// Ports: clk, rst (sync, active-high); tbl_we/tbl_addr/tbl_wdata node-table write;
// req_valid/req_ready/req_class request; out_valid/out_ready/out_inp match stream;
// done one-cycle sweep-complete pulse; depth_err sticky walk-limit flag.
// Optional macro DTC_INV_COUNT_EN adds match_cnt (matches transferred in the current sweep).
module dtc_inverse_enum
    import dtc_pkg::*;
#(
    parameter int N_NODES   = 32,
    parameter int MAX_DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       tbl_we,
    input  logic [$clog2(N_NODES)-1:0] tbl_addr,
    input  logic [15:0]                tbl_wdata,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [CLS_W-1:0]           req_class,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [INP_W-1:0]           out_inp,
    output logic                       done,
    output logic                       depth_err
`ifdef DTC_INV_COUNT_EN
    ,
    output logic [7:0]                 match_cnt
`endif
);

    localparam int AW = $clog2(N_NODES);
    localparam int SW = $clog2(MAX_DEPTH + 1);

    state_t           r_state;
    logic [CLS_W-1:0] r_target;
    logic [INP_W-1:0] r_cand;
    logic [AW-1:0]    r_node;
    logic [SW-1:0]    r_step;

    logic [15:0]      w_rdata;
    node_t            w_node;
    logic             w_bit;
    logic             w_limit;
    logic             w_advance;

    dtc_node_ram #(.N_NODES(N_NODES), .AW(AW)) u_ram (
        .clk   (clk),
        .we    (tbl_we),
        .waddr (tbl_addr),
        .wdata (tbl_wdata),
        .raddr (r_node),
        .rdata (w_rdata)
    );

    assign w_node  = node_t'(w_rdata);
    assign w_bit   = r_cand[feat_idx(w_node.feat)];
    // Current node is the MAX_DEPTH-th visited for this candidate.
    assign w_limit = (r_step == SW'(MAX_DEPTH - 1));

    // Move on to the next candidate: leaf of another class, walk limit hit, or match handed off.
    always_comb begin
        w_advance = 1'b0;
        if (r_state == S_WALK) begin
            if (w_node.leaf) begin
                w_advance = (w_node.cls != r_target);
            end else begin
                w_advance = w_limit;
            end
        end else if (r_state == S_EMIT) begin
            w_advance = out_ready;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_target  <= '0;
            r_cand    <= '0;
            r_node    <= '0;
            r_step    <= '0;
            req_ready <= 1'b1;
            out_valid <= 1'b0;
            out_inp   <= '0;
            done      <= 1'b0;
            depth_err <= 1'b0;
`ifdef DTC_INV_COUNT_EN
            match_cnt <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_target  <= req_class;
                        r_cand    <= '0;
                        r_node    <= '0;
                        r_step    <= '0;
                        depth_err <= 1'b0;
                        req_ready <= 1'b0;
                        r_state   <= S_WALK;
`ifdef DTC_INV_COUNT_EN
                        match_cnt <= '0;
`endif
                    end
                end
                S_WALK: begin
                    if (w_node.leaf) begin
                        if (w_node.cls == r_target) begin
                            out_valid <= 1'b1;
                            out_inp   <= r_cand;
                            r_state   <= S_EMIT;
                        end
                    end else if (w_limit) begin
                        depth_err <= 1'b1;
                    end else begin
                        r_step <= r_step + 1'b1;
                        r_node <= w_bit ? AW'(w_node.hi_child) : AW'(w_node.lo_child);
                    end
                end
                S_EMIT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
`ifdef DTC_INV_COUNT_EN
                        match_cnt <= match_cnt + 8'd1;
`endif
                    end
                end
                S_FIN: begin
                    done      <= 1'b0;
                    req_ready <= 1'b1;
                    r_state   <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase

            if (w_advance) begin
                if (r_cand == '1) begin
                    // Last candidate: finish instead of wrapping to 0.
                    done    <= 1'b1;
                    r_state <= S_FIN;
                end else begin
                    r_cand  <= r_cand + 1'b1;
                    r_node  <= '0;
                    r_step  <= '0;
                    r_state <= S_WALK;
                end
            end
        end
    end

endmodule

// File: tb/tb_dtc_inverse_enum.sv
// tb/tb_dtc_inverse_enum.sv - self-checking bench for dtc_inverse_enum
module tb_dtc_inverse_enum;
    import dtc_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tbl_we = 1'b0;
    logic [4:0] tbl_addr = '0;
    logic [15:0] tbl_wdata = '0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [1:0] req_class = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [6:0] out_inp;
    logic       done;
    logic       depth_err;
`ifdef DTC_INV_COUNT_EN
    logic [7:0] match_cnt;
`endif

    int checks = 0;
    int errors = 0;
    logic [6:0] exp_q[$];

    always #5 clk = ~clk;

    dtc_inverse_enum #(.N_NODES(32), .MAX_DEPTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .tbl_we    (tbl_we),
        .tbl_addr  (tbl_addr),
        .tbl_wdata (tbl_wdata),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_class (req_class),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_inp   (out_inp),
        .done      (done),
        .depth_err (depth_err)
`ifdef DTC_INV_COUNT_EN
        ,
        .match_cnt (match_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [15:0] d);
        tbl_we = 1'b1; tbl_addr = a; tbl_wdata = d;
        tick();
        tbl_we = 1'b0;
    endtask

    task automatic request(input logic [1:0] c);
        check("req_ready_idle", req_ready, 1);
        req_valid = 1'b1; req_class = c;
        tick();
        req_valid = 1'b0;
        check("req_ready_busy", req_ready, 0);
        check("depth_err_cleared", depth_err, 0);
    endtask

    task automatic push_odds();
        for (int i = 1; i < 128; i += 2) exp_q.push_back(7'(i));
    endtask

    // Runs the sweep; stalls the first match for `stall` cycles, returns early after `stop_after` transfers.
    task automatic sweep(input int stall, input int stop_after, output int n, output bit got_done);
        n = 0; got_done = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (done) begin
                got_done = 1;
                check("queue_empty_at_done", exp_q.size(), 0);
                break;
            end
            if (out_valid) begin
                if (stall > 0) begin
                    out_ready = 1'b0;
                    check("held_out_inp", out_inp, (exp_q.size() > 0) ? exp_q[0] : 7'h7f);
                    stall--;
                end else begin
                    out_ready = 1'b1;
                    if (exp_q.size() == 0) begin
                        check("unexpected_output", out_inp, 999);
                    end else begin
                        check("out_inp", out_inp, exp_q.pop_front());
                    end
                    n++;
                    if (stop_after > 0 && n == stop_after) return;
                end
            end else begin
                out_ready = 1'b1;
            end
            tick();
        end
        if (!got_done) check("sweep_timeout", 0, 1);
    endtask

    task automatic after_done();
        tick();
        check("done_one_cycle", done, 0);
        check("req_ready_after_fin", req_ready, 1);
    endtask

    int  n;
    bit  gd;

    initial begin
        tick(); tick();
        check("rst_req_ready", req_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_inp", out_inp, 0);
        check("rst_done", done, 0);
        check("rst_depth_err", depth_err, 0);
        rst = 1'b0;
        tick();

        // Single leaf of class 2: every input matches.
        wr(5'd0, make_node(1'b1, 3'd0, 2'd2, 5'd0, 5'd0));
        for (int i = 0; i < 128; i++) exp_q.push_back(7'(i));
        request(2'd2);
        sweep(0, 0, n, gd);
        check("all_count", n, 128);
        check("all_done", gd, 1);
        check("all_depth_err", depth_err, 0);
        after_done();

        // Split on bit 0: odd inputs are class 1.
        wr(5'd0, make_node(1'b0, 3'd0, 2'd0, 5'd1, 5'd2));
        wr(5'd1, make_node(1'b1, 3'd0, 2'd0, 5'd0, 5'd0));
        wr(5'd2, make_node(1'b1, 3'd0, 2'd1, 5'd0, 5'd0));
        push_odds();
        request(2'd1);
        sweep(0, 0, n, gd);
        check("odd_count", n, 64);
        check("odd_done", gd, 1);
`ifdef DTC_INV_COUNT_EN
        check("match_cnt", match_cnt, 64);
`endif
        after_done();

        // Backpressure on first match.
        push_odds();
        request(2'd1);
        sweep(10, 0, n, gd);
        check("stall_count", n, 64);
        check("stall_done", gd, 1);
        after_done();

        // No leaf reaches class 3.
        request(2'd3);
        sweep(0, 0, n, gd);
        check("none_count", n, 0);
        check("none_done", gd, 1);
        after_done();

        // Feature 7 aliases bit 6: upper half of input space is class 1.
        wr(5'd0, make_node(1'b0, 3'd7, 2'd0, 5'd1, 5'd2));
        for (int i = 64; i < 128; i++) exp_q.push_back(7'(i));
        request(2'd1);
        sweep(0, 0, n, gd);
        check("feat7_count", n, 64);
        after_done();

        // Self-loop: walk limit on every candidate.
        wr(5'd0, make_node(1'b0, 3'd0, 2'd0, 5'd0, 5'd0));
        request(2'd0);
        sweep(0, 0, n, gd);
        check("loop_count", n, 0);
        check("loop_done", gd, 1);
        check("loop_depth_err", depth_err, 1);
        after_done();

        // Reset mid-sweep after 5 matches.
        wr(5'd0, make_node(1'b0, 3'd0, 2'd0, 5'd1, 5'd2));
        push_odds();
        request(2'd1);
        check("depth_err_new_req", depth_err, 0);
        sweep(0, 5, n, gd);
        check("abort_count", n, 5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_out_valid", out_valid, 0);
        check("abort_req_ready", req_ready, 1);
        check("abort_done", done, 0);
        exp_q.delete();
        for (int i = 0; i < 4; i++) begin
            tick();
            check("abort_no_done", done, 0);
        end
        push_odds();
        request(2'd1);
        sweep(0, 0, n, gd);
        check("restart_count", n, 64);
        check("restart_done", gd, 1);
        after_done();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
